// File: rtl/rv_mem_responder_pkg.sv
// Shared types and helpers for the rv memory responder: access sizes, FSM states, alignment check.
package rv_mem_responder_pkg;

    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        MEM_B   = 2'd0,
        MEM_H   = 2'd1,
        MEM_W   = 2'd2,
        MEM_RSV = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Natural alignment check on the low address bits; reserved size is handled by the caller.
    function automatic logic mem_misaligned(input logic [1:0] addr, input mem_size_t size);
        case (size)
            MEM_H:   return addr[0];
            MEM_W:   return |addr;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_mem_responder_lane.sv
// Byte-lane logic for the rv memory responder: byte enables, write-data steering and
// right-alignment of read data (upper bits zero).
module rv_mem_responder_lane
    import rv_mem_responder_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wlanes,
    output logic [31:0] o_rdata
);

    mem_size_t   w_size;
    logic [31:0] w_shift;

    always_comb begin
        w_size   = mem_size_t'(i_size);
        w_shift  = i_word >> {i_addr_lo, 3'b000};
        o_be     = 4'b0000;
        o_wlanes = i_wdata;
        o_rdata  = '0;
        case (w_size)
            MEM_B: begin
                o_be     = 4'b0001 << i_addr_lo;
                o_wlanes = {4{i_wdata[7:0]}};
                o_rdata  = {24'd0, w_shift[7:0]};
            end
            MEM_H: begin
                o_be     = 4'b0011 << i_addr_lo;
                o_wlanes = {2{i_wdata[15:0]}};
                o_rdata  = {16'd0, w_shift[15:0]};
            end
            MEM_W: begin
                o_be    = 4'b1111;
                o_rdata = w_shift;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv_mem_responder.sv
// rv_mem_responder: little-endian byte-addressed RAM answering the rv core bus with
// WAIT_CYCLES wait states and fault reporting. Define RV_MEM_LOADER_EN for the image loader port.
module rv_mem_responder
    import rv_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_bus_oe,
    output logic        o_ready,
    output logic        o_err
`ifdef RV_MEM_LOADER_EN
    ,
    input  logic        i_ld_valid,
    input  logic [31:0] i_ld_addr,
    input  logic [7:0]  i_ld_data,
    output logic        o_ld_ready
`endif
);

    localparam int unsigned IDX_W = ADDR_BITS - 2;
    localparam int unsigned WORDS = 1 << IDX_W;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

    mem_state_t             r_state;
    logic [WAIT_CNT_W-1:0]  r_cnt;
    logic                   r_we;
    mem_size_t              r_size;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic [31:0]            r_mem [WORDS];

    logic                   w_acc_we;
    mem_size_t              w_acc_size;
    logic [31:0]            w_acc_addr;
    logic [31:0]            w_acc_wdata;
    logic [IDX_W-1:0]       w_acc_idx;
    logic                   w_fault;
    logic                   w_rd_ok;
    logic                   w_to_resp;
    logic                   w_core_we;
    logic [31:0]            w_word;
    logic [3:0]             w_be;
    logic [31:0]            w_lanes;
    logic [31:0]            w_rdata;
    logic                   w_wr_en;
    logic [IDX_W-1:0]       w_wr_idx;
    logic [3:0]             w_wr_be;
    logic [31:0]            w_wr_data;

    // In IDLE the live request is decoded (needed for the zero-wait path), otherwise the latched one.
    always_comb begin
        w_acc_we    = r_we;
        w_acc_size  = r_size;
        w_acc_addr  = r_addr;
        w_acc_wdata = r_wdata;
        if (r_state == IDLE) begin
            w_acc_we    = i_we;
            w_acc_size  = mem_size_t'(i_size);
            w_acc_addr  = i_addr;
            w_acc_wdata = i_wdata;
        end
    end

    assign w_acc_idx = w_acc_addr[ADDR_BITS-1:2];
    assign w_fault   = (w_acc_size == MEM_RSV)
                     || mem_misaligned(w_acc_addr[1:0], w_acc_size)
                     || (|w_acc_addr[31:ADDR_BITS]);
    assign w_rd_ok   = !w_acc_we && !w_fault;
    assign w_word    = r_mem[w_acc_idx];
    assign w_to_resp = ((r_state == IDLE) && i_req && (WAIT_CYCLES == 0))
                     || ((r_state == WAIT) && (r_cnt == '0));
    assign w_core_we = (r_state == RESP) && r_we && !w_fault;

    rv_mem_responder_lane u_lane (
        .i_addr_lo (w_acc_addr[1:0]),
        .i_size    (w_acc_size),
        .i_wdata   (w_acc_wdata),
        .i_word    (w_word),
        .o_be      (w_be),
        .o_wlanes  (w_lanes),
        .o_rdata   (w_rdata)
    );

`ifdef RV_MEM_LOADER_EN
    logic w_ld_we;
    assign o_ld_ready = !i_rst && (r_state == IDLE) && !i_req && i_ld_valid;
    assign w_ld_we    = o_ld_ready && !(|i_ld_addr[31:ADDR_BITS]);
`endif

    // Single RAM write port shared by core commits (RESP) and loader bytes (IDLE).
    always_comb begin
        w_wr_en   = w_core_we;
        w_wr_idx  = w_acc_idx;
        w_wr_be   = w_be;
        w_wr_data = w_lanes;
`ifdef RV_MEM_LOADER_EN
        if (w_ld_we) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = i_ld_addr[ADDR_BITS-1:2];
            w_wr_be   = 4'b0001 << i_ld_addr[1:0];
            w_wr_data = {4{i_ld_data}};
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wr_be[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_size   <= MEM_B;
            r_addr   <= '0;
            r_wdata  <= '0;
            o_ready  <= 1'b0;
            o_err    <= 1'b0;
            o_bus_oe <= 1'b0;
            o_rdata  <= '0;
        end else begin
            o_ready  <= w_to_resp;
            o_err    <= w_to_resp && w_fault;
            o_bus_oe <= w_to_resp && w_rd_ok;
            o_rdata  <= (w_to_resp && w_rd_ok) ? w_rdata : '0;
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        r_we    <= i_we;
                        r_size  <= mem_size_t'(i_size);
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) r_state <= RESP;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_mem_responder.sv
// Scoreboard bench for rv_mem_responder: three instances (WAIT_CYCLES 1/0/3) driven in turn,
// expected responses from a byte-array reference model, checked by one negedge monitor.
module tb_rv_mem_responder;

    localparam int ADDR_BITS = 10;
    localparam int MEM_BYTES = 1 << ADDR_BITS;
    localparam int N_DUT     = 3;

    typedef struct {
        int          due;
        logic        err;
        logic        oe;
        logic        chk_rd;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N_DUT-1:0]        rst, req, we, bus_oe, ready, err;
    logic [N_DUT-1:0][1:0]   size;
    logic [N_DUT-1:0][31:0]  addr, wdata, rdata;
`ifdef RV_MEM_LOADER_EN
    logic [N_DUT-1:0]        ld_valid, ld_ready, exp_ld_ready;
    logic [N_DUT-1:0][31:0]  ld_addr;
    logic [N_DUT-1:0][7:0]   ld_data;
`endif

    logic [7:0] mdl [N_DUT][MEM_BYTES];
    exp_t       sb_q [N_DUT][$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    rv_mem_responder #(.ADDR_BITS(ADDR_BITS), .WAIT_CYCLES(1)) u_dut0 (
        .i_clk(clk), .i_rst(rst[0]), .i_req(req[0]), .i_we(we[0]), .i_size(size[0]),
        .i_addr(addr[0]), .i_wdata(wdata[0]), .o_rdata(rdata[0]), .o_bus_oe(bus_oe[0]),
        .o_ready(ready[0]), .o_err(err[0])
`ifdef RV_MEM_LOADER_EN
        , .i_ld_valid(ld_valid[0]), .i_ld_addr(ld_addr[0]), .i_ld_data(ld_data[0]),
        .o_ld_ready(ld_ready[0])
`endif
    );

    rv_mem_responder #(.ADDR_BITS(ADDR_BITS), .WAIT_CYCLES(0)) u_dut1 (
        .i_clk(clk), .i_rst(rst[1]), .i_req(req[1]), .i_we(we[1]), .i_size(size[1]),
        .i_addr(addr[1]), .i_wdata(wdata[1]), .o_rdata(rdata[1]), .o_bus_oe(bus_oe[1]),
        .o_ready(ready[1]), .o_err(err[1])
`ifdef RV_MEM_LOADER_EN
        , .i_ld_valid(ld_valid[1]), .i_ld_addr(ld_addr[1]), .i_ld_data(ld_data[1]),
        .o_ld_ready(ld_ready[1])
`endif
    );

    rv_mem_responder #(.ADDR_BITS(ADDR_BITS), .WAIT_CYCLES(3)) u_dut2 (
        .i_clk(clk), .i_rst(rst[2]), .i_req(req[2]), .i_we(we[2]), .i_size(size[2]),
        .i_addr(addr[2]), .i_wdata(wdata[2]), .o_rdata(rdata[2]), .o_bus_oe(bus_oe[2]),
        .o_ready(ready[2]), .o_err(err[2])
`ifdef RV_MEM_LOADER_EN
        , .i_ld_valid(ld_valid[2]), .i_ld_addr(ld_addr[2]), .i_ld_data(ld_data[2]),
        .o_ld_ready(ld_ready[2])
`endif
    );

    function automatic int wc_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : 3;
    endfunction

    // An access faults on reserved size, any address past the RAM, or an address not a multiple of its size.
    function automatic logic mdl_fault(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (a >= 32'(MEM_BYTES)) return 1'b1;
        return (a % (32'd1 << sz)) != 32'd0;
    endfunction

    // Apply one accepted access to the model and build its expected response.
    task automatic model_access(input int d, input logic w, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] wd,
                                input int acc, output exp_t e);
        e.due    = acc + wc_of(d) + 1;
        e.err    = mdl_fault(sz, a);
        e.oe     = !w && !e.err;
        e.chk_rd = !w || e.err;
        e.rdata  = '0;
        if (!e.err) begin
            for (int i = 0; i < (1 << sz); i++) begin
                if (w) mdl[d][ADDR_BITS'(a + 32'(i))] = wd[8*i +: 8];
                else   e.rdata[8*i +: 8] = mdl[d][ADDR_BITS'(a + 32'(i))];
            end
        end
    endtask

    task automatic wait_idle(input int d);
        for (int k = 0; k < 60 && sb_q[d].size() != 0; k++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input int d, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; size[d] = sz; addr[d] = a; wdata[d] = wd;
        @(posedge clk); #1;
        req[d] = 1'b0;
        model_access(d, w, sz, a, wd, cyc, e);
        sb_q[d].push_back(e);
        wait_idle(d);
    endtask

    // req held high: each new accept lands on the first IDLE edge after the previous RESP.
    task automatic held_reads(input int d, input logic [31:0] a, input int k);
        exp_t e;
        int   acc0;
        int   p;
        p = wc_of(d) + 2;
        @(negedge clk);
        req[d] = 1'b1; we[d] = 1'b0; size[d] = 2'd2; addr[d] = a;
        @(posedge clk); #1;
        acc0 = cyc;
        for (int j = 0; j < k; j++) begin
            model_access(d, 1'b0, 2'd2, a, 32'd0, acc0 + j * p, e);
            sb_q[d].push_back(e);
        end
        repeat (k * p - 1) @(posedge clk);
        #1 req[d] = 1'b0;
        wait_idle(d);
    endtask

    // Accepted write aborted by reset: nothing pushed, model untouched.
    task automatic reset_mid_write(input int d);
        @(negedge clk);
        req[d] = 1'b1; we[d] = 1'b1; size[d] = 2'd2; addr[d] = 32'h10; wdata[d] = 32'h12345678;
        @(posedge clk); #1;
        req[d] = 1'b0;
        rst[d] = 1'b1;
        repeat (3) @(negedge clk);
        rst[d] = 1'b0;
        @(negedge clk);
    endtask

`ifdef RV_MEM_LOADER_EN
    task automatic loader_tests(input int d);
        logic [31:0] img;
        exp_t        e;
        img = 32'h00500013;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            ld_valid[d] = 1'b1; ld_addr[d] = 32'(i); ld_data[d] = img[8*i +: 8];
            exp_ld_ready[d] = 1'b1;
            mdl[d][i] = img[8*i +: 8];
        end
        @(posedge clk); #1;
        ld_addr[d] = 32'h401; ld_data[d] = 8'hAA;
        @(posedge clk); #1;
        ld_valid[d] = 1'b0; exp_ld_ready[d] = 1'b0;
        issue(d, 1'b0, 2'd2, 32'h0, 32'd0);
        @(posedge clk); #1;
        req[d] = 1'b1; we[d] = 1'b0; size[d] = 2'd2; addr[d] = 32'h0;
        ld_valid[d] = 1'b1; ld_addr[d] = 32'h0; ld_data[d] = 8'hFF;
        @(posedge clk); #1;
        req[d] = 1'b0; ld_valid[d] = 1'b0;
        model_access(d, 1'b0, 2'd2, 32'h0, 32'd0, cyc, e);
        sb_q[d].push_back(e);
        wait_idle(d);
        issue(d, 1'b0, 2'd2, 32'h0, 32'd0);
    endtask
`endif

    task automatic run_suite(input int d);
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        issue(d, 1'b1, 2'd2, 32'h0,   32'h11223344);
        issue(d, 1'b1, 2'd2, 32'h40,  32'hDEADBEEF);
        issue(d, 1'b0, 2'd2, 32'h40,  32'd0);
        issue(d, 1'b0, 2'd0, 32'h43,  32'd0);
        issue(d, 1'b0, 2'd1, 32'h42,  32'd0);
        issue(d, 1'b1, 2'd0, 32'h41,  32'h00000055);
        issue(d, 1'b0, 2'd2, 32'h40,  32'd0);
        issue(d, 1'b0, 2'd1, 32'h41,  32'd0);
        issue(d, 1'b1, 2'd2, 32'h400, 32'hFFFFFFFF);
        issue(d, 1'b0, 2'd2, 32'h0,   32'd0);
        issue(d, 1'b0, 2'd3, 32'h40,  32'd0);
        issue(d, 1'b1, 2'd2, 32'h3FC, 32'hA5A55A5A);
        issue(d, 1'b0, 2'd2, 32'h3FC, 32'd0);
        issue(d, 1'b1, 2'd1, 32'h3FF, 32'h0000BEEF);
        issue(d, 1'b0, 2'd0, 32'h3FF, 32'd0);
        issue(d, 1'b0, 2'd0, 32'h400, 32'd0);
        held_reads(d, 32'h40, 3);
        issue(d, 1'b1, 2'd2, 32'h10, 32'hCAFEF00D);
        reset_mid_write(d);
        issue(d, 1'b0, 2'd2, 32'h10, 32'd0);
        for (int i = 0; i < 64; i++) issue(d, 1'b1, 2'd2, 32'h100 + 32'(4 * i), $urandom);
        for (int n = 0; n < 80; n++) begin
            w  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'h100 + 32'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h400;
            issue(d, w, sz, a, $urandom);
        end
`ifdef RV_MEM_LOADER_EN
        loader_tests(d);
`endif
    endtask

    // Monitor: every negedge, compare each DUT against its scoreboard and the idle/reset rules.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < N_DUT; d++) begin
            if (rst[d]) begin
                checks++;
                if (ready[d] || err[d] || bus_oe[d] || rdata[d] != 32'd0) begin
                    failures++;
                    $display("FAIL reset_outputs dut%0d: ready=%b err=%b bus_oe=%b rdata=%h, required all zero",
                             d, ready[d], err[d], bus_oe[d], rdata[d]);
                end
            end else if (ready[d]) begin
                checks++;
                if (sb_q[d].size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ready dut%0d at edge %0d: err=%b rdata=%h, required no response",
                             d, cyc + 1, err[d], rdata[d]);
                end else begin
                    e = sb_q[d].pop_front();
                    if ((cyc + 1) != e.due || err[d] != e.err || bus_oe[d] != e.oe
                        || (e.chk_rd && rdata[d] != e.rdata)) begin
                        failures++;
                        $display("FAIL rsp dut%0d: got edge=%0d err=%b bus_oe=%b rdata=%h, required edge=%0d err=%b bus_oe=%b rdata=%h",
                                 d, cyc + 1, err[d], bus_oe[d], rdata[d], e.due, e.err, e.oe, e.rdata);
                    end
                end
            end else begin
                checks++;
                if (err[d] || bus_oe[d]) begin
                    failures++;
                    $display("FAIL idle_strobe dut%0d: err=%b bus_oe=%b, required 0 without ready",
                             d, err[d], bus_oe[d]);
                end
                if (sb_q[d].size() != 0 && (cyc + 1) > sb_q[d][0].due) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_ready dut%0d: no ready by edge %0d, required at edge %0d",
                             d, cyc + 1, sb_q[d][0].due);
                    void'(sb_q[d].pop_front());
                end
            end
`ifdef RV_MEM_LOADER_EN
            checks++;
            if (ld_ready[d] !== exp_ld_ready[d]) begin
                failures++;
                $display("FAIL ld_ready dut%0d: got %b, required %b", d, ld_ready[d], exp_ld_ready[d]);
            end
`endif
        end
    end

    initial begin
        rst = '1; req = '0; we = '0; size = '0; addr = '0; wdata = '0;
`ifdef RV_MEM_LOADER_EN
        ld_valid = '0; ld_addr = '0; ld_data = '0; exp_ld_ready = '0;
`endif
        repeat (3) @(negedge clk);
        rst = '0;
        @(negedge clk);
        for (int d = 0; d < N_DUT; d++) run_suite(d);
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
